// File: rtl/peri_bus_pkg.sv
// Shared types and constants for the peripheral bus controller.
// The optional WAIT timeout is enabled with the PBUS_TIMEOUT_EN macro.
package peri_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } pbus_state_e;

  localparam int unsigned PBUS_DW           = 32;
  localparam int unsigned PBUS_NUM_PERI_DEF = 8;

  localparam int unsigned PERI_UART  = 0;
  localparam int unsigned PERI_GPIO  = 1;
  localparam int unsigned PERI_SPI   = 2;
  localparam int unsigned PERI_CSR   = 3;
  localparam int unsigned PERI_CSRAM = 4;
  localparam int unsigned PERI_DDMA  = 5;
  localparam int unsigned PERI_DMA   = 6;
  localparam int unsigned PERI_DRA   = 7;

  // True when a select-field value lands on an existing slave.
  function automatic logic pbus_sel_hit(input logic [31:0] field,
                                        input logic [31:0] base,
                                        input logic [31:0] num);
    return (field >= base) && ((field - base) < num);
  endfunction

endpackage

// File: rtl/peri_bus_rmux.sv
// Combinational index-select of the per-slave ready and read-data buses.
// Only the addressed slave can reach the outputs; all others read as 0.
module peri_bus_rmux
  import peri_bus_pkg::*;
#(
  parameter int unsigned NUM_PERI = PBUS_NUM_PERI_DEF,
  parameter int unsigned IDX_W    = 4
) (
  input  logic [IDX_W-1:0]            i_idx,
  input  logic [NUM_PERI-1:0]         i_ready,
  input  logic [NUM_PERI*PBUS_DW-1:0] i_rdata,
  output logic                        o_ready,
  output logic [PBUS_DW-1:0]          o_rdata
);

  always_comb begin
    o_ready = 1'b0;
    o_rdata = '0;
    for (int unsigned k = 0; k < NUM_PERI; k++) begin
      if (32'(i_idx) == k) begin
        o_ready = i_ready[k];
        o_rdata = i_rdata[k*PBUS_DW +: PBUS_DW];
      end
    end
  end

endmodule

// File: rtl/peri_bus_ctrl.sv
// Peripheral bus controller: one outstanding core transaction, decoded to NUM_PERI slaves.
// Define PBUS_TIMEOUT_EN to end a WAIT with an error after TIMEOUT_CYC cycles without ready.
module peri_bus_ctrl
  import peri_bus_pkg::*;
#(
  parameter int unsigned NUM_PERI    = PBUS_NUM_PERI_DEF,
  parameter int unsigned SEL_LSB     = 16,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned SEL_BASE    = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_peri_rden,
  input  logic                     i_peri_wren,
  input  logic [31:0]              i_peri_addr,
  input  logic [31:0]              i_peri_wdata,
  input  logic [3:0]               i_peri_wstrb,
  output logic                     o_peri_gnt,
  output logic                     o_peri_ready,
  output logic [31:0]              o_peri_rdata,
  output logic                     o_peri_err,
  output logic [31:0]              o_addr_2peri,
  output logic [NUM_PERI-1:0]      o_wren_2peri,
  output logic [NUM_PERI-1:0]      o_rden_2peri,
  output logic [31:0]              o_wdata_2peri,
  output logic [3:0]               o_wstrb_2peri,
  input  logic [NUM_PERI-1:0]      i_ready_2PBUS,
  input  logic [NUM_PERI*32-1:0]   i_rdata_2PBUS,
  output pbus_state_e              o_dbg_state
);

  // Handshake: the core may hold rden/wren at any time, but a request is taken only
  // on a clock edge where o_peri_gnt=1; completion is the single-cycle o_peri_ready
  // pulse, with o_peri_rdata/o_peri_err valid then and held until the next completion.

  pbus_state_e      state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             is_wr_q, is_wr_d;
  logic             miss_q, miss_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] field;
  logic             hit;
  logic             sel_ready;
  logic [31:0]      sel_rdata;

  assign field = i_peri_addr[SEL_LSB +: SEL_W];
  assign hit   = pbus_sel_hit(32'(field), SEL_BASE, NUM_PERI);

  peri_bus_rmux #(
    .NUM_PERI (NUM_PERI),
    .IDX_W    (SEL_W)
  ) u_rmux (
    .i_idx   (idx_q),
    .i_ready (i_ready_2PBUS),
    .i_rdata (i_rdata_2PBUS),
    .o_ready (sel_ready),
    .o_rdata (sel_rdata)
  );

`ifdef PBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    is_wr_d = is_wr_q;
    miss_d  = miss_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef PBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_q && (i_peri_rden || i_peri_wren)) begin
          addr_d  = i_peri_addr;
          wdata_d = i_peri_wdata;
          wstrb_d = i_peri_wstrb;
          is_wr_d = i_peri_wren;
          miss_d  = !hit;
          idx_d   = field - SEL_W'(SEL_BASE);
          state_d = ST_REQ;
        end
      end
      // A decode miss spends this cycle with the strobes suppressed, then answers.
      ST_REQ: begin
        if (miss_q) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
`ifdef PBUS_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (sel_ready) begin
          rdata_d = is_wr_q ? 32'h0 : sel_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
`ifdef PBUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    gnt_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      is_wr_q <= 1'b0;
      miss_q  <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef PBUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      is_wr_q <= is_wr_d;
      miss_q  <= miss_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef PBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    o_wren_2peri = '0;
    o_rden_2peri = '0;
    if (state_q == ST_REQ && !miss_q) begin
      for (int unsigned k = 0; k < NUM_PERI; k++) begin
        if (32'(idx_q) == k) begin
          o_wren_2peri[k] = is_wr_q;
          o_rden_2peri[k] = !is_wr_q;
        end
      end
    end
  end

  assign o_peri_gnt    = gnt_q;
  assign o_peri_ready  = (state_q == ST_RESP);
  assign o_peri_rdata  = rdata_q;
  assign o_peri_err    = err_q;
  assign o_addr_2peri  = addr_q;
  assign o_wdata_2peri = wdata_q;
  assign o_wstrb_2peri = wstrb_q;
  assign o_dbg_state   = state_q;

endmodule
